// File: rtl/adc_serial_arbiter.sv
// Arbitrates three requesters onto a single ADC serial port and shifts out 32-bit register frames.
// Define ADC_SERIAL_RR_EN for round-robin arbitration; otherwise fixed priority (Req[0] highest).
module adc_serial_arbiter #(
  parameter int unsigned SCLK_DIV = 4,
  parameter int unsigned NUM_REQ  = 3
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Enable,
  input  logic [NUM_REQ-1:0]     Req,
  input  logic [4*NUM_REQ-1:0]   ReqAddr,
  input  logic [16*NUM_REQ-1:0]  ReqData,
  output logic [NUM_REQ-1:0]     Grant,
  output logic [NUM_REQ-1:0]     Done,
  output logic                   Busy,
  output logic                   Sclk,
  output logic                   Sdata,
  output logic                   Select
);

  localparam logic [7:0] HalfLoad = 8'(SCLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          half_q, half_d;
  logic [4:0]          bit_q, bit_d;
  logic                phase_q, phase_d;
  logic [31:0]         frame_q, frame_d;
  logic [1:0]          owner_q, owner_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                select_q, select_d;
  logic                armed_q;

  logic [1:0]          win_idx;
  logic                grant_ok;
  logic [3:0]          win_addr;
  logic [15:0]         win_data;

  function automatic logic [1:0] pick3(input logic [2:0] r, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] c);
    if (r[a]) return a;
    else if (r[b]) return b;
    else return c;
  endfunction

`ifdef ADC_SERIAL_RR_EN
  logic [1:0] last_q, last_d;

  // Search begins at the requester after the last winner.
  always_comb begin
    unique case (last_q)
      2'd0:    win_idx = pick3(Req, 2'd1, 2'd2, 2'd0);
      2'd1:    win_idx = pick3(Req, 2'd2, 2'd0, 2'd1);
      default: win_idx = pick3(Req, 2'd0, 2'd1, 2'd2);
    endcase
  end
`else
  always_comb begin
    win_idx = pick3(Req, 2'd0, 2'd1, 2'd2);
  end
`endif

  // armed_q keeps the first arbitration behind the first clock edge after reset release.
  assign grant_ok = (state_q == StIdle) && armed_q && Enable && (done_q == '0) && (|Req);
  assign Grant    = grant_ok ? (NUM_REQ'(1) << win_idx) : '0;
  assign win_addr = ReqAddr[{win_idx, 2'b00} +: 4];
  assign win_data = ReqData[{win_idx, 4'b0000} +: 16];

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    frame_d = frame_q;
    owner_d = owner_q;
    done_d  = '0;
`ifdef ADC_SERIAL_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_ok) begin
          state_d = StSetup;
          half_d  = HalfLoad;
          frame_d = {12'h001, win_addr, win_data};
          owner_d = win_idx;
`ifdef ADC_SERIAL_RR_EN
          last_d  = win_idx;
`endif
        end
      end
      StSetup: begin
        if (half_q == 8'd0) begin
          state_d = StShift;
          half_d  = HalfLoad;
          bit_d   = 5'd31;
          phase_d = 1'b0;
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      StShift: begin
        // phase_q low = Sclk low half of the current bit, high = Sclk high half.
        if (half_q == 8'd0) begin
          half_d = HalfLoad;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == 5'd0) begin
            state_d = StHold;
            phase_d = 1'b0;
          end else begin
            bit_d   = bit_q - 5'd1;
            phase_d = 1'b0;
          end
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      StHold: begin
        if (half_q == 8'd0) begin
          state_d = StGap;
          half_d  = HalfLoad;
          phase_d = 1'b0;
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      StGap: begin
        // Two half-periods of deselect before returning to arbitration.
        if (half_q == 8'd0) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            half_d  = HalfLoad;
          end else begin
            state_d = StIdle;
            phase_d = 1'b0;
            done_d  = NUM_REQ'(1) << owner_q;
          end
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Serial pins are registered from next-state so they are glitch-free.
  always_comb begin
    sclk_d   = (state_d == StShift) && phase_d;
    sdata_d  = ((state_d == StShift) || (state_d == StHold)) ? frame_d[bit_d] : 1'b0;
    select_d = !((state_d == StSetup) || (state_d == StShift) || (state_d == StHold));
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      half_q   <= 8'd0;
      bit_q    <= 5'd0;
      phase_q  <= 1'b0;
      frame_q  <= 32'd0;
      owner_q  <= 2'd0;
      done_q   <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      select_q <= 1'b1;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      frame_q  <= frame_d;
      owner_q  <= owner_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      select_q <= select_d;
      armed_q  <= 1'b1;
    end
  end

`ifdef ADC_SERIAL_RR_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_q <= 2'd0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign Done   = done_q;
  assign Busy   = (state_q != StIdle);
  assign Sclk   = sclk_q;
  assign Sdata  = sdata_q;
  assign Select = select_q;

endmodule

// File: tb/tb_adc_serial_arbiter.sv
// Bench for adc_serial_arbiter: directed scenarios plus randomized traffic against a
// frame-timing reference model evaluated every cycle.
module tb_adc_serial_arbiter;

  localparam int D = 4;

  logic        Clock   = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Enable  = 1'b0;
  logic [2:0]  Req     = 3'b000;
  logic [11:0] ReqAddr = 12'h000;
  logic [47:0] ReqData = 48'h0;
  logic [2:0]  Grant;
  logic [2:0]  Done;
  logic        Busy;
  logic        Sclk;
  logic        Sdata;
  logic        Select;

  adc_serial_arbiter #(
    .SCLK_DIV (D),
    .NUM_REQ  (3)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Enable  (Enable),
    .Req     (Req),
    .ReqAddr (ReqAddr),
    .ReqData (ReqData),
    .Grant   (Grant),
    .Done    (Done),
    .Busy    (Busy),
    .Sclk    (Sclk),
    .Sdata   (Sdata),
    .Select  (Select)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  logic [31:0] samp = 32'h0;
  always @(posedge Sclk) samp <= {samp[30:0], Sdata};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at cyc=%0d", name, cyc);
  endtask

  // Reference model: a frame is described only by its grant time, winner and word.
  logic        m_armed;
  bit          m_active = 1'b0;
  int          m_t      = 0;
  int          m_win    = 0;
  int          m_last   = 0;
  logic [31:0] m_frame  = 32'h0;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) m_armed <= 1'b0;
    else          m_armed <= 1'b1;
  end

  function automatic int pick(input logic [2:0] r, input int last);
`ifdef ADC_SERIAL_RR_EN
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (r[c]) return c;
    end
`else
    for (int c = 0; c < 3; c++) begin
      if (r[c]) return c;
    end
`endif
    return 0;
  endfunction

  always @(negedge Clock) begin
    logic [2:0] eg, ed;
    logic       es, eb, esc, esd;
    int         s;
    if (!Reset_n) begin
      chk("rst_select", 32'(Select), 32'd1);
      chk("rst_sclk", 32'(Sclk), 32'd0);
      chk("rst_sdata", 32'(Sdata), 32'd0);
      chk("rst_grant", 32'(Grant), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      m_active = 1'b0;
      m_last   = 0;
    end else begin
      eg = 3'b000;
      ed = 3'b000;
      if (!m_active && m_armed && Enable && (Req != 3'b000)) begin
        m_win    = pick(Req, m_last);
        m_last   = m_win;
        m_active = 1'b1;
        m_t      = 0;
        m_frame  = {12'h001, ReqAddr[4*m_win +: 4], ReqData[16*m_win +: 16]};
        eg       = 3'(1 << m_win);
      end
      es  = 1'b1;
      eb  = 1'b0;
      esc = 1'b0;
      s   = -1;
      if (m_active) begin
        es  = !(m_t >= 1 && m_t <= 66*D);
        eb  = (m_t >= 1 && m_t <= 68*D);
        s   = m_t - (D + 1);
        esc = (s >= 0 && s < 64*D && (s % (2*D)) >= D);
        if (m_t == 68*D + 1) ed = 3'(1 << m_win);
      end
      chk("grant", 32'(Grant), 32'(eg));
      chk("done", 32'(Done), 32'(ed));
      chk("select", 32'(Select), 32'(es));
      chk("busy", 32'(Busy), 32'(eb));
      chk("sclk", 32'(Sclk), 32'(esc));
      if (m_active && m_t >= D + 1 && m_t <= 66*D) begin
        esd = (s < 64*D) ? m_frame[31 - s/(2*D)] : m_frame[0];
        chk("sdata", 32'(Sdata), 32'(esd));
      end
      if (m_active) begin
        if (m_t == 68*D + 1) m_active = 1'b0;
        else m_t++;
      end
    end
  end

  task automatic wait_grant(input string name, input int budget, output int gc,
                            output logic [2:0] g);
    gc = -1;
    g  = 3'b000;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (Grant != 3'b000) begin
        gc = cyc;
        g  = Grant;
        return;
      end
    end
    expire(name);
  endtask

  task automatic wait_done(input string name, input int budget, output int dc,
                           output logic [2:0] d);
    dc = -1;
    d  = 3'b000;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (Done != 3'b000) begin
        dc = cyc;
        d  = Done;
        return;
      end
    end
    expire(name);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          t, dc, nlow, first, hi, g2c;
    logic [2:0]  g, dv, g2, gseen;
    logic [3:0]  ra;
    logic [15:0] rd;
    bit          found;
    int          ngr;

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    #2 Reset_n = 1'b1;

    // Single host request, literal frame timing.
    step();
    Enable  = 1'b1;
    Req     = 3'b100;
    ReqAddr = {4'h9, 8'h00};
    ReqData = {16'h8FFF, 32'h0};
    wait_grant("host_grant_wait", 20, t, g);
    chk("host_grant", 32'(g), 32'(3'b100));
    step();
    Req   = 3'b000;
    nlow  = 0;
    first = -1;
    found = 1'b0;
    dc    = -1;
    dv    = 3'b000;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge Clock);
      if (!Select) begin
        if (nlow == 0) first = cyc;
        nlow++;
      end
      if (Done != 3'b000) begin
        found = 1'b1;
        dc    = cyc;
        dv    = Done;
      end
    end
    if (!found) expire("host_done_wait");
    chk("host_select_low_cycles", 32'(nlow), 32'd264);
    chk("host_select_fall_offset", 32'(first - t), 32'd1);
    chk("host_done_offset", 32'(dc - t), 32'd273);
    chk("host_done_value", 32'(dv), 32'(3'b100));
    chk("host_frame", samp, 32'h0019_8FFF);

    // All three requesting continuously.
    step();
    ReqAddr = {4'hC, 4'h5, 4'hA};
    ReqData = {16'h1234, 16'hBEEF, 16'h0F0F};
    Req     = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_grant("all_grant_wait", 400, t, g);
`ifdef ADC_SERIAL_RR_EN
      case (k)
        0: chk("all_grant_0", 32'(g), 32'(3'b001));
        1: chk("all_grant_1", 32'(g), 32'(3'b010));
        2: chk("all_grant_2", 32'(g), 32'(3'b100));
        default: chk("all_grant_3", 32'(g), 32'(3'b001));
      endcase
`else
      chk("all_grant_fixed", 32'(g), 32'(3'b001));
`endif
    end
    step();
    Req = 3'b000;
    wait_done("all_done_wait", 400, dc, dv);
    chk("all_last_frame", samp, {12'h001, 4'hA, 16'h0F0F});

    // Enable low blocks grants; dropping it mid-frame does not abort.
    step();
    Enable = 1'b0;
    Req    = 3'b010;
    ngr    = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clock);
      if (Grant != 3'b000) ngr++;
    end
    chk("enable_low_no_grant", 32'(ngr), 32'd0);
    step();
    Enable = 1'b1;
    wait_grant("enable_grant_wait", 5, t, g);
    chk("enable_grant", 32'(g), 32'(3'b010));
    step();
    Enable = 1'b0;
    Req    = 3'b000;
    wait_done("enable_done_wait", 400, dc, dv);
    chk("enable_done", 32'(dv), 32'(3'b010));
    chk("enable_done_offset", 32'(dc - t), 32'(68*D + 1));

    // Late request from calibration during a power-FSM frame.
    step();
    Enable  = 1'b1;
    Req     = 3'b001;
    ReqAddr = {4'h0, 4'h7, 4'h3};
    ReqData = {16'h0, 16'h5A5A, 16'hC3C3};
    wait_grant("late_grant0_wait", 5, t, g);
    chk("late_grant0", 32'(g), 32'(3'b001));
    step();
    Req = 3'b000;
    repeat (4) @(posedge Clock);
    #1 Req = 3'b010;
    hi    = 0;
    dc    = -1;
    dv    = 3'b000;
    g2c   = -1;
    g2    = 3'b000;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge Clock);
      hi = Select ? hi + 1 : 0;
      if (Done != 3'b000) begin
        dc = cyc;
        dv = Done;
      end
      if (Grant != 3'b000) begin
        g2c   = cyc;
        g2    = Grant;
        found = 1'b1;
      end
    end
    if (!found) expire("late_grant1_wait");
    chk("late_done0", 32'(dv), 32'(3'b001));
    chk("late_grant1", 32'(g2), 32'(3'b010));
    chk("late_grant_after_done", 32'(g2c - dc), 32'd1);
    chk("late_gap_ge_2d", 32'(hi >= 2*D), 32'd1);
    step();
    Req = 3'b000;
    wait_done("late_done1_wait", 400, dc, dv);
    chk("late_frame1", samp, {12'h001, 4'h7, 16'h5A5A});

    // Reset in the middle of a frame.
    step();
    ra      = 4'($urandom);
    rd      = 16'($urandom);
    ReqAddr = {ra, 8'h00};
    ReqData = {rd, 32'h0};
    Req     = 3'b100;
    wait_grant("rst_grant_wait", 5, t, g);
    repeat (100) @(posedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_mid_select", 32'(Select), 32'd1);
    chk("rst_mid_sclk", 32'(Sclk), 32'd0);
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    chk("rst_mid_done", 32'(Done), 32'd0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    #2 Reset_n = 1'b1;
    wait_grant("rst_regrant_wait", 10, t, g);
    chk("rst_regrant", 32'(g), 32'(3'b100));
    step();
    Req = 3'b000;
    wait_done("rst_done_wait", 400, dc, dv);
    chk("rst_done", 32'(dv), 32'(3'b100));
    chk("rst_frame", samp, {12'h001, ra, rd});

    // Randomized traffic; the per-cycle model does the checking.
    gseen = 3'b000;
    for (int n = 0; n < 6000; n++) begin
      @(negedge Clock);
      gseen = Grant;
      step();
      for (int i = 0; i < 3; i++) begin
        if (!Req[i]) begin
          if ($urandom_range(29) == 0) begin
            Req[i]            = 1'b1;
            ReqAddr[4*i +: 4]  = 4'($urandom);
            ReqData[16*i +: 16] = 16'($urandom);
          end
        end else if (gseen[i]) begin
          if ($urandom_range(1) == 0) begin
            Req[i] = 1'b0;
          end else begin
            ReqAddr[4*i +: 4]  = 4'($urandom);
            ReqData[16*i +: 16] = 16'($urandom);
          end
        end else if ($urandom_range(399) == 0) begin
          Req[i] = 1'b0;
        end
      end
      if ($urandom_range(99) == 0) Enable = !Enable;
    end
    step();
    Req    = 3'b000;
    Enable = 1'b1;
    repeat (700) @(posedge Clock);
    @(negedge Clock);
    chk("final_idle_busy", 32'(Busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_serial_arbiter.md
ADC_SERIAL_ARBITER -- requirements
Module: adc_serial_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; parameters SHALL be:
- SCLK_DIV, 4, Clock cycles per Sclk half-period (D), legal range 2..255.
- NUM_REQ, 3, number of requesters, fixed at 3.
REQ-002 The ports SHALL be:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Enable  in  1  new grants allowed when high.
- Req  in  3  per-requester level request; bit 0 is the power FSM, bit 1 is calibration, bit 2 is host.
- ReqAddr  in  12  packed 4-bit register addresses; requester i uses [4i+3:4i].
- ReqData  in  48  packed 16-bit register data; requester i uses [16i+15:16i].
- Grant  out  3  one-hot, one-cycle grant pulse.
- Done  out  3  one-hot, one-cycle completion pulse to the granted requester.
- Busy  out  1  high whenever the state is not IDLE.
- Sclk  out  1  ADC serial clock; idles low.
- Sdata  out  1  ADC serial data, MSB first.
- Select  out  1  ADC chip select, active low.

Function
REQ-003 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-004 Arbitration SHALL occur only in IDLE with Enable=1 and Req!=0: in that cycle T, exactly one Grant bit pulses, the winner's ReqAddr/ReqData are latched, and the state moves to SETUP.
REQ-005 Frame SHALL be 32 bits: 12'h001 header, then 4-bit address, then 16-bit data, MSB first.
REQ-006 Select SHALL go low at T+1 and stay low for exactly 66*D cycles: SETUP for D cycles, SHIFT for 64*D cycles, HOLD for D cycles.
REQ-007 In SHIFT, each bit SHALL be driven as follows:
- Sdata updates at the start of the bit's low phase.
- Sclk is low for D cycles, then high for D cycles.
- The ADC samples on the Sclk rising edge.
REQ-008 HOLD SHALL keep Sclk low and Sdata at bit 0.
REQ-009 GAP SHALL keep Select high for 2*D cycles.
REQ-010 Done[winner] SHALL pulse at T+1+68*D, and the state SHALL return to IDLE in the same cycle.
REQ-011 A requester SHALL hold Req, ReqAddr and ReqData stable until its Grant.
REQ-012 Req still high in the cycle after Done SHALL be treated as a new request.
REQ-013 Req dropped before Grant SHALL produce no frame and no Done.
REQ-014 Enable falling mid-frame SHALL NOT abort the frame; it SHALL only block the next grant.
REQ-015 Changes to Req or inputs mid-frame SHALL have no effect on the frame in progress.
REQ-016 Grant and Done SHALL never be asserted in the same cycle.
REQ-017 No more than one Grant bit and no more than one Done bit SHALL be high in any cycle.
REQ-018 The internal bit counter SHALL count 31 down to 0 with no wrap; the half-period counter SHALL reload at D-1.

Reset
REQ-019 When Reset_n is low, the outputs SHALL take these values immediately, without waiting for a clock edge:
- State is IDLE.
- Select=1, Sclk=0, Sdata=0.
- Grant=0, Done=0, Busy=0.
- Round-robin pointer points at requester 0 as last granted.
REQ-020 Reset asserted mid-frame SHALL truncate the frame, produce no Done, and forget the latched request.
REQ-021 After Reset_n deasserts, the first arbitration SHALL occur no earlier than the first Clock edge.

Configuration
REQ-022 When ADC_SERIAL_RR_EN is defined, arbitration SHALL be round-robin:
- Search starts at the requester after the last winner, in order 0,1,2.
- The pointer updates on each Grant.
REQ-023 When ADC_SERIAL_RR_EN is undefined, arbitration SHALL be fixed priority with Req[0] highest and Req[2] lowest, and no pointer SHALL exist.

Verification
REQ-024 Single host request, D=4, ReqAddr[11:8]=4'h9, ReqData[47:32]=16'h8FFF:
- Grant=3'b100 at T.
- Select low at cycles T+1..T+264.
- Sampled frame is 32'h0019_8FFF.
- Done=3'b100 at T+273.
REQ-025 Req=3'b111 held continuously:
- With RR_EN, grants go 0,1,2,0.
- Without RR_EN, every grant goes to requester 0.
REQ-026 Reset_n pulsed low at T+100 of a frame:
- Select=1 and Sclk=0 with no clock edge needed.
- No Done is issued.
- The next frame after reset is complete and correct.
REQ-027 Enable=0 with Req=3'b010:
- No Grant while Enable is low.
- Enable dropped mid-frame: the frame completes and Done pulses.
REQ-028 Req[1] raised at T+5 during requester 0's frame: Req[1] is granted in the cycle after Done[0], and a Select-high gap of 2*D cycles is observed before its frame.
